// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial operand feeder: FSM state encoding and
// the bit-counter width helper.
package serial_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-counter width for a word of the given width; never below one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sum_deser.sv
// Deserialises the sum bit stream returned by the downstream serial adder
// into a parallel result. Bits arrive LSB first, one per bit_valid cycle;
// the result is loaded and flagged in the cycle after the last bit.
module serial_sum_deser
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             last,
    input  logic             sum,
    output logic [WIDTH-1:0] res,
    output logic             res_valid
);

    // Holds the WIDTH-1 bits received so far; the newest bit enters at the top.
    logic [WIDTH-2:0] cap_q, cap_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] word;

    assign word = {sum, cap_q};

    // Next-state: shift on live bits, load the result on the last bit.
    always_comb begin
        cap_d       = cap_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        if (bit_valid) begin
            cap_d = word[WIDTH-1:1];
            if (last) begin
                res_d       = word;
                res_valid_d = 1'b1;
            end
        end
    end

    // Capture shift register carries data only and needs no reset.
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    // Result register and its one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;

endmodule

// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: accepts a parallel operand pair and streams both
// operands LSB first, one bit per cycle, to a downstream serial adder.
// A new pair can be accepted in the last-bit cycle for gapless streaming.
// Optional feature macro SERIAL_FEEDER_SUM_CAPTURE_EN adds the sum input and
// a parallel result capture (res / res_valid) via serial_sum_deser.
module serial_operand_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
`ifdef SERIAL_FEEDER_SUM_CAPTURE_EN
    input  logic             sum,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
`endif
    output logic             busy
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE      = CW'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             bit_valid_q, bit_valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             last_bit;
    logic             accept;

    // The current cycle is presenting bit WIDTH-1 of a word.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign in_ready = (state_q == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;

    // Next-state and next-output logic. Bit 0 of an accepted pair goes straight
    // to the output flops; the shift registers keep the remaining bits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        a_d         = 1'b0;
        b_d         = 1'b0;
        bit_valid_d = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        if (accept) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            a_d         = in_a[0];
            b_d         = in_b[0];
            sh_a_d      = in_a >> 1;
            sh_b_d      = in_b >> 1;
            bit_valid_d = 1'b1;
            first_d     = 1'b1;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d       = cnt_q + ONE;
                a_d         = sh_a_q[0];
                b_d         = sh_b_q[0];
                sh_a_d      = sh_a_q >> 1;
                sh_b_d      = sh_b_q >> 1;
                bit_valid_d = 1'b1;
                last_d      = ((cnt_q + ONE) == LAST_IDX);
            end
        end
        busy_d = (state_d == SHIFT);
    end

    // Control and output flops; reset discards any partially sent word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bit_valid_q <= bit_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
        end
    end

    // Operand shift registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        sh_a_q <= sh_a_d;
        sh_b_q <= sh_b_d;
    end

    assign a         = a_q;
    assign b         = b_q;
    assign bit_valid = bit_valid_q;
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = busy_q;

`ifdef SERIAL_FEEDER_SUM_CAPTURE_EN
    serial_sum_deser #(
        .WIDTH(WIDTH)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .bit_valid(bit_valid_q),
        .last     (last_q),
        .sum      (sum),
        .res      (res),
        .res_valid(res_valid)
    );
`endif

endmodule
